// File: rtl/ray_request_arbiter_if.sv
// Requester/result bus of ray_request_arbiter: flattened per-requester positions in,
// tagged calcRay results out.
interface ray_request_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*IN_W-1:0] req_x;
  logic [N_REQ*IN_W-1:0] req_y;
  logic [N_REQ*IN_W-1:0] req_z;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic [OUT_W-1:0]      res_xsq;
  logic [OUT_W-1:0]      res_ysq;
  logic [OUT_W-1:0]      res_zsq;
  logic [OUT_W-1:0]      res_r;

  modport master (
    output req_valid, req_x, req_y, req_z,
    input  req_ready, res_valid, res_id, res_xsq, res_ysq, res_zsq, res_r
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z,
    output req_ready, res_valid, res_id, res_xsq, res_ysq, res_zsq, res_r
  );
endinterface

// File: rtl/ray_request_arbiter.sv
// Round-robin arbiter sharing one fixed-latency calc_ray datapath between N_REQ requesters.
// Define RAY_ARB_LATCHECK_EN to add a sticky lat_err output (tag tail vs datapath valid).

// x^2, y^2, z^2 and r = sqrt(x^2+y^2+z^2), rescaled to OUT_FRAC and saturated to OUT_W; LAT >= 2.
module calc_ray #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned IN_FRAC  = 7,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned OUT_FRAC = 7,
  parameter int unsigned LAT      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef RAY_ARB_LATCHECK_EN
  input  logic                   in_valid,
  output logic                   out_valid,
`endif
  input  logic signed [IN_W-1:0] x,
  input  logic signed [IN_W-1:0] y,
  input  logic signed [IN_W-1:0] z,
  output logic [OUT_W-1:0]       xsq,
  output logic [OUT_W-1:0]       ysq,
  output logic [OUT_W-1:0]       zsq,
  output logic [OUT_W-1:0]       r
);
  localparam int unsigned SQ_W  = 2 * IN_W;
  localparam int unsigned SUM_W = 2 * IN_W + 1;
  localparam int unsigned RT_W  = (2 * IN_W + 2) / 2;
  localparam int unsigned SQR_W = 2 * RT_W;
  localparam int unsigned SQ_SH = 2 * IN_FRAC - OUT_FRAC;
  localparam int unsigned RT_SH = IN_FRAC - OUT_FRAC;

  function automatic logic [OUT_W-1:0] sat_sq(input logic [SQ_W-1:0] v);
    logic [SQ_W-1:0] s;
    s = v >> SQ_SH;
    return (|(s >> OUT_W)) ? '1 : OUT_W'(s);
  endfunction

  function automatic logic [OUT_W-1:0] sat_rt(input logic [RT_W-1:0] v);
    logic [RT_W-1:0] s;
    s = v >> RT_SH;
    return (|(s >> OUT_W)) ? '1 : OUT_W'(s);
  endfunction

  // Bit-serial floor(sqrt(v)): keep each root bit whose trial square still fits.
  function automatic logic [RT_W-1:0] isqrt(input logic [SUM_W-1:0] v);
    logic [RT_W-1:0]  root;
    logic [RT_W-1:0]  cand;
    logic [SQR_W-1:0] cand_sq;
    root = '0;
    for (int i = int'(RT_W) - 1; i >= 0; i--) begin
      cand    = root | (RT_W'(1) << i);
      cand_sq = SQR_W'(cand) * SQR_W'(cand);
      if (cand_sq <= SQR_W'(v)) root = cand;
    end
    return root;
  endfunction

  logic signed [SQ_W-1:0] xe, ye, ze;
  logic [SQ_W-1:0]        xsq_c, ysq_c, zsq_c;
  logic [SUM_W-1:0]       sum_c;

  always_comb begin
    xe    = SQ_W'(x);
    ye    = SQ_W'(y);
    ze    = SQ_W'(z);
    xsq_c = SQ_W'(xe * xe);
    ysq_c = SQ_W'(ye * ye);
    zsq_c = SQ_W'(ze * ze);
    sum_c = SUM_W'(xsq_c) + SUM_W'(ysq_c) + SUM_W'(zsq_c);
  end

  logic [LAT-1:0][OUT_W-1:0] xsq_q, ysq_q, zsq_q, r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsq_q <= '0;
      ysq_q <= '0;
      zsq_q <= '0;
      r_q   <= '0;
    end else begin
      xsq_q <= {xsq_q[LAT-2:0], sat_sq(xsq_c)};
      ysq_q <= {ysq_q[LAT-2:0], sat_sq(ysq_c)};
      zsq_q <= {zsq_q[LAT-2:0], sat_sq(zsq_c)};
      r_q   <= {r_q[LAT-2:0], sat_rt(isqrt(sum_c))};
    end
  end

  assign xsq = xsq_q[LAT-1];
  assign ysq = ysq_q[LAT-1];
  assign zsq = zsq_q[LAT-1];
  assign r   = r_q[LAT-1];

`ifdef RAY_ARB_LATCHECK_EN
  logic [LAT-1:0] valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= {valid_q[LAT-2:0], in_valid};
  end
  assign out_valid = valid_q[LAT-1];
`endif
endmodule

module ray_request_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned IN_FRAC  = 7,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned OUT_FRAC = 7,
  parameter int unsigned CALC_LAT = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic flush,
  output logic flush_done,
  output logic busy,
`ifdef RAY_ARB_LATCHECK_EN
  output logic lat_err,
`endif
  ray_request_arbiter_if.slave bus
);
  localparam int unsigned CALC_INST_LAT = 6;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STOPPED} state_t;

  state_t                      state, state_next;
  logic [ID_W-1:0]             last_grant, win_c, cand_c;
  logic                        found_c, hs_c, pipe_empty_c;
  logic [N_REQ-1:0]            grant_c;
  logic [IN_W-1:0]             sel_x_c, sel_y_c, sel_z_c;
  logic                        issue_valid;
  logic [ID_W-1:0]             issue_id;
  logic signed [IN_W-1:0]      issue_x, issue_y, issue_z;
  logic [CALC_LAT-1:0]         tag_valid;
  logic [CALC_LAT-1:0][ID_W-1:0] tag_id;
  logic [OUT_W-1:0]            calc_xsq, calc_ysq, calc_zsq, calc_r;
  logic                        calc_rst;

  assign pipe_empty_c  = !issue_valid && (tag_valid == '0);
  assign hs_c          = |(bus.req_valid & grant_c);
  assign bus.req_ready = grant_c;
  assign calc_rst      = ~reset;

  // Next state plus round-robin search starting one past the last granted requester.
  always_comb begin
    state_next = state;
    grant_c    = '0;
    win_c      = last_grant;
    cand_c     = last_grant;
    found_c    = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = ID_W'((32'(last_grant) + k) % N_REQ);
      if (!found_c && bus.req_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
    case (state)
      IDLE:    if (enable && !flush) state_next = RUN;
      RUN: begin
        if (found_c) grant_c[win_c] = 1'b1;
        if (flush)        state_next = DRAIN;
        else if (!enable) state_next = IDLE;
      end
      DRAIN:   if (pipe_empty_c) state_next = STOPPED;
      STOPPED: if (!flush) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_x_c = '0;
    sel_y_c = '0;
    sel_z_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        sel_x_c = bus.req_x[i*IN_W +: IN_W];
        sel_y_c = bus.req_y[i*IN_W +: IN_W];
        sel_z_c = bus.req_z[i*IN_W +: IN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= ID_W'(N_REQ - 1);
      issue_valid   <= 1'b0;
      issue_id      <= '0;
      issue_x       <= '0;
      issue_y       <= '0;
      issue_z       <= '0;
      tag_valid     <= '0;
      tag_id        <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_xsq   <= '0;
      bus.res_ysq   <= '0;
      bus.res_zsq   <= '0;
      bus.res_r     <= '0;
      busy          <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      state       <= state_next;
      issue_valid <= hs_c;
      if (hs_c) begin
        last_grant <= win_c;
        issue_id   <= win_c;
        issue_x    <= sel_x_c;
        issue_y    <= sel_y_c;
        issue_z    <= sel_z_c;
      end
      // Tag tail lines up with the datapath output; results hold between strobes.
      tag_valid     <= {tag_valid[CALC_LAT-2:0], issue_valid};
      tag_id        <= {tag_id[CALC_LAT-2:0], issue_id};
      bus.res_valid <= tag_valid[CALC_LAT-1];
      if (tag_valid[CALC_LAT-1]) begin
        bus.res_id  <= tag_id[CALC_LAT-1];
        bus.res_xsq <= calc_xsq;
        bus.res_ysq <= calc_ysq;
        bus.res_zsq <= calc_zsq;
        bus.res_r   <= calc_r;
      end
      busy       <= hs_c | issue_valid | (|tag_valid[CALC_LAT-2:0]);
      flush_done <= (state_next == STOPPED);
    end
  end

`ifdef RAY_ARB_LATCHECK_EN
  logic calc_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                lat_err <= 1'b0;
    else if (tag_valid[CALC_LAT-1] != calc_valid) lat_err <= 1'b1;
  end
`endif

  calc_ray #(
    .IN_W    (IN_W),
    .IN_FRAC (IN_FRAC),
    .OUT_W   (OUT_W),
    .OUT_FRAC(OUT_FRAC),
    .LAT     (CALC_INST_LAT)
  ) u_calc (
    .clk      (clk),
    .rst      (calc_rst),
`ifdef RAY_ARB_LATCHECK_EN
    .in_valid (issue_valid),
    .out_valid(calc_valid),
`endif
    .x        (issue_x),
    .y        (issue_y),
    .z        (issue_z),
    .xsq      (calc_xsq),
    .ysq      (calc_ysq),
    .zsq      (calc_zsq),
    .r        (calc_r)
  );
endmodule

// File: tb/tb_ray_request_arbiter.sv
// Randomized bench for ray_request_arbiter against a queue-based behavioural model.
module tb_ray_request_arbiter;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned IN_W     = 8;
  localparam int unsigned IN_FRAC  = 7;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned OUT_FRAC = 7;
  localparam int unsigned CALC_LAT = 6;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_STOP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic flush_done, busy;
`ifdef RAY_ARB_LATCHECK_EN
  logic lat_err;
`endif

  ray_request_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  ray_request_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .IN_W(IN_W), .IN_FRAC(IN_FRAC),
    .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .CALC_LAT(CALC_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .flush_done(flush_done),
    .busy      (busy),
`ifdef RAY_ARB_LATCHECK_EN
    .lat_err   (lat_err),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    int xsq, ysq, zsq, r;
  } res_t;

  res_t pend[$];
  int   cyc = 0;
  int   mode = M_IDLE;
  int   last = N_REQ - 1;
  int   exp_id = 0, exp_xsq = 0, exp_ysq = 0, exp_zsq = 0, exp_r = 0;
  int   vectors = 0, miscompares = 0;
  int   results_seen = 0;
  logic [N_REQ-1:0] ready_seen;
  logic [IN_W-1:0]  xv[N_REQ], yv[N_REQ], zv[N_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sq_ref(input int v);
    int s;
    s = (v * v) / (1 << (2 * IN_FRAC - OUT_FRAC));
    return (s > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : s;
  endfunction

  function automatic int r_ref(input int x, input int y, input int z);
    int s;
    s = int'($floor($sqrt(real'(x * x + y * y + z * z)))) / (1 << (IN_FRAC - OUT_FRAC));
    return (s > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : s;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < int'(N_REQ); i++) begin
      xv[i] = IN_W'($urandom);
      yv[i] = IN_W'($urandom);
      zv[i] = IN_W'($urandom);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic en, input logic fl, input logic [N_REQ-1:0] v);
    int   win, c, xi, yi, zi;
    logic exp_v, busy_e;
    logic [N_REQ-1:0] exp_ready;
    res_t item;
    enable = en;
    flush  = fl;
    bus.req_valid = v;
    for (int i = 0; i < int'(N_REQ); i++) begin
      bus.req_x[i*IN_W +: IN_W] = xv[i];
      bus.req_y[i*IN_W +: IN_W] = yv[i];
      bus.req_z[i*IN_W +: IN_W] = zv[i];
    end
    #1;
    exp_v = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_v   = 1'b1;
      exp_id  = pend[0].id;
      exp_xsq = pend[0].xsq;
      exp_ysq = pend[0].ysq;
      exp_zsq = pend[0].zsq;
      exp_r   = pend[0].r;
      void'(pend.pop_front());
    end
    busy_e = (pend.size() > 0);
    win = -1;
    if (mode == M_RUN) begin
      for (int k = 1; k <= int'(N_REQ); k++) begin
        c = (last + k) % int'(N_REQ);
        if (win < 0 && v[c]) win = c;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    ready_seen = bus.req_ready;
    if (bus.res_valid === 1'b1) results_seen++;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("res_valid", 32'(bus.res_valid), 32'(exp_v));
    if (exp_v) check("res_id", 32'(bus.res_id), 32'(exp_id));
    check("res_xsq", 32'(bus.res_xsq), 32'(exp_xsq));
    check("res_ysq", 32'(bus.res_ysq), 32'(exp_ysq));
    check("res_zsq", 32'(bus.res_zsq), 32'(exp_zsq));
    check("res_r", 32'(bus.res_r), 32'(exp_r));
    check("busy", 32'(busy), 32'(busy_e));
    check("flush_done", 32'(flush_done), 32'(mode == M_STOP));
    if (win >= 0) begin
      xi = int'($signed(xv[win]));
      yi = int'($signed(yv[win]));
      zi = int'($signed(zv[win]));
      item.due = cyc + int'(CALC_LAT) + 2;
      item.id  = win;
      item.xsq = sq_ref(xi);
      item.ysq = sq_ref(yi);
      item.zsq = sq_ref(zi);
      item.r   = r_ref(xi, yi, zi);
      pend.push_back(item);
      last = win;
    end
    case (mode)
      M_IDLE:  if (en && !fl) mode = M_RUN;
      M_RUN:   if (fl) mode = M_DRAIN; else if (!en) mode = M_IDLE;
      M_DRAIN: if (!busy_e) mode = M_STOP;
      default: if (!fl) mode = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_res_r", 32'(bus.res_r), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    pend.delete();
    mode = M_IDLE;
    last = N_REQ - 1;
    exp_id = 0; exp_xsq = 0; exp_ysq = 0; exp_zsq = 0; exp_r = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
  endtask

  initial begin
    int n0, budget;
    bit seen;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_z = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      xv[i] = '0; yv[i] = '0; zv[i] = '0;
    end
    #2;
    do_reset();
    step(1'b0, 1'b0, '0);

    // Single request from requester 2: x = 0.5
    xv[2] = 8'h40;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 4'b0100);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    check("single_id", 32'(bus.res_id), 32'd2);
    check("single_r", 32'(bus.res_r), 32'h40);
    check("single_xsq", 32'(bus.res_xsq), 32'h20);

    // All requesters streaming for 12 cycles
    n0 = results_seen;
    for (int i = 0; i < 12; i++) begin
      randomize_data();
      step(1'b1, 1'b0, '1);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    check("stream_count", 32'(results_seen - n0), 32'd12);

    // Most negative input on every axis
    xv[0] = 8'h80; yv[0] = 8'h80; zv[0] = 8'h80;
    step(1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    check("neg_r", 32'(bus.res_r), 32'hDD);
    check("neg_xsq", 32'(bus.res_xsq), 32'h80);

    // Flush while streaming, held until the pipeline reports drained
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      step(1'b1, 1'b0, '1);
    end
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 40) begin
      randomize_data();
      step(1'b1, 1'b1, '1);
      seen = (flush_done === 1'b1);
      budget++;
    end
    check("flush_done_seen", 32'(seen), 32'd1);
    step(1'b1, 1'b0, '1);
    step(1'b1, 1'b0, '0);

    // Reset with tags in flight
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      step(1'b1, 1'b0, '1);
    end
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '1);
    step(1'b1, 1'b0, '1);
    step(1'b1, 1'b0, '1);
    check("rst_first_grant", 32'(ready_seen), 32'd1);

    // Random traffic with enable drops and flush pulses
    for (int i = 0; i < 400; i++) begin
      randomize_data();
      step(($urandom % 8) != 0, ($urandom % 20) == 0, N_REQ'($urandom));
    end
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0);

`ifdef RAY_ARB_LATCHECK_EN
    check("lat_err", 32'(lat_err), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
